gcd_ctrl: RTL
=============

GCD_CTRL -- requirements
Module: gcd_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port clr_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port start, input, 1 bit: request a computation; sampled at the rising edge only in IDLE.
REQ-005 Port abort, input, 1 bit: cancel an in-progress computation.
REQ-006 Port xin, input, 4 bits: first operand, unsigned.
REQ-007 Port yin, input, 4 bits: second operand, unsigned.
REQ-008 Port busy, output, 1 bit: high in LOAD and CALC.
REQ-009 Port done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-010 Port gcd, output, 4 bits: last completed result; held until the next completion.
REQ-011 Port err, output, 1 bit: set with done when both operands were 0; cleared on the next accepted start.

Function
REQ-012 The block SHALL contain two 4-bit working registers, x and y, each with its own load enable.
REQ-013 x and y SHALL be written only by the FSM: load from xin/yin, or load the subtractor result.
REQ-014 The FSM SHALL have states IDLE, LOAD, CALC, DONE, encoded in 2 bits.
REQ-015 IDLE: start=1 at an edge -> capture xin into x, capture yin into y, clear err, go to LOAD; otherwise stay in IDLE.
REQ-016 LOAD: one-cycle settle state; the next edge always goes to CALC.
REQ-017 CALC: exactly one decision per edge, evaluated in this priority order:
  - x==0 and y==0 -> gcd<=0, err<=1, go to DONE.
  - x==0 -> gcd<=y, go to DONE.
  - y==0 -> gcd<=x, go to DONE.
  - x==y -> gcd<=x, go to DONE.
  - x>y -> x<=x-y, stay in CALC.
  - otherwise -> y<=y-x, stay in CALC.
REQ-018 Subtraction SHALL be 4-bit unsigned; borrow cannot occur because the larger value is always the minuend.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 Latency: let k be the number of subtractions. Counting the edge that samples start as edge 0, done SHALL be high in the cycle after edge k+2.
REQ-021 The worst case is xin=15, yin=1: k=14, so done is high after edge 16.
REQ-022 start asserted in LOAD, CALC or DONE SHALL be ignored; it is not queued.
REQ-023 abort=1 in LOAD or CALC SHALL return the FSM to IDLE at the next edge.
REQ-024 On abort, done SHALL not pulse and gcd/err SHALL keep their previous values.
REQ-025 abort in IDLE or DONE SHALL have no effect.
REQ-026 If start and abort are both 1 in IDLE, start SHALL win.
REQ-027 xin/yin changes after the start-sampling edge SHALL not affect the computation in progress.
REQ-028 busy, done, gcd and err SHALL be registered outputs with no combinational path from any input.

Reset
REQ-029 When clr_n=0, the block SHALL immediately, independent of clk, force state=IDLE, x=0, y=0, gcd=0, err=0, busy=0, done=0.
REQ-030 Reset asserted mid-computation SHALL discard the operation; no done pulse SHALL follow reset release.
REQ-031 The first start SHALL be accepted at the first clock edge after clr_n rises.

Verification
REQ-032 Start with xin=12, yin=8 -> x=4 after edge 2, y=4 after edge 3; done=1 and gcd=4 after edge 4, err=0.
REQ-033 Start with xin=9, yin=9 -> done after edge 2, gcd=9.
REQ-034 Start with xin=15, yin=1 -> busy for 16 cycles, done after edge 16, gcd=1.
REQ-035 Start with xin=0, yin=6 -> gcd=6, err=0; start with xin=0, yin=0 -> gcd=0, err=1; the next start clears err.
REQ-036 Start 15,1, then start 6,4 while busy -> second request ignored, gcd=1. Run 6,4 to gcd=2, then start 15,1 and abort at edge 5 -> IDLE, no done, gcd stays 2.
REQ-037 Start 14,6, then pull clr_n low after edge 3 -> all outputs 0 immediately. Release clr_n and start 14,6 -> gcd=2.

Source files
------------

// File: rtl/gcd_ctrl.sv
// gcd_ctrl: iterative subtract-based GCD of two 4-bit unsigned operands.
// Handshake: start launches a computation, abort cancels it, and done
// pulses for one cycle with the result on gcd.
// err flags the 0/0 case.
// All outputs come straight from flops.
module gcd_ctrl (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] xin,
  input  logic [3:0] yin,
  output logic       busy,
  output logic       done,
  output logic [3:0] gcd,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e     state_q;
  logic [3:0] x_q, y_q;
  logic [3:0] gcd_q;
  logic       err_q, busy_q, done_q;

  // Subtractor results for the working registers.
  // The larger value is always the minuend when a result is used,
  // so no borrow can reach x or y.
  logic [3:0] x_sub_d, y_sub_d;

  // Both differences are computed every cycle; the FSM picks the one it needs.
  always_comb begin
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    x_sub_d = x_q - y_q;
    y_sub_d = y_q - x_q;
  end

  // Control FSM together with the working registers and the registered outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    // NOTE: all state, the working registers included, is cleared asynchronously.
    // After reset nothing stale can reach gcd, and no done pulse can follow.
    if (!clr_n) begin
      state_q <= IDLE;
      x_q     <= 4'd0;
      y_q     <= 4'd0;
      gcd_q   <= 4'd0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout.
      // Each decision therefore sees the register values from before this edge.
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // start wins over abort here; abort has no meaning in IDLE.
          if (start) begin
            x_q     <= xin;
            y_q     <= yin;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= CALC;
          end
        end
        CALC: begin
          if (abort) begin
            // Cancel silently: gcd and err keep the previous result.
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (x_q == 4'd0 && y_q == 4'd0) begin
            gcd_q   <= 4'd0;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (x_q == 4'd0) begin
            gcd_q   <= y_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (y_q == 4'd0 || x_q == y_q) begin
            gcd_q   <= x_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (x_q > y_q) begin
            x_q <= x_sub_d;
          end else begin
            y_q <= y_sub_d;
          end
        end
        DONE: begin
          // Single-cycle pulse state.
          // A start seen here is dropped, not queued.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gcd  = gcd_q;
  assign err  = err_q;

endmodule
